mem_test_ctrl: RTL

MEM_TEST_CTRL -- requirements
Module: mem_test_ctrl

---
 rtl/mem_test_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_test_ctrl.sv
// Self-test controller: writes an address-derived pattern to a RAM, reads it back and counts miscompares.
// Optional MEM_TEST_INVERT_PASS_EN adds a second pass using the bitwise-inverted pattern.
module mem_test_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   ERR_MAX   = {(ADDR_WIDTH+1){1'b1}};

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   chk_addr_r;
  logic                    chk_valid_r;
  logic                    mis_s;
  logic [ADDR_WIDTH:0]     err_next_s;
  logic [ADDR_WIDTH-1:0]   ffa_next_s;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a);
    return (p << ADDR_WIDTH) | p;
  endfunction

`ifdef MEM_TEST_INVERT_PASS_EN
  logic inv_r;

  function automatic logic [DATA_WIDTH-1:0] phase_pat(input logic [ADDR_WIDTH-1:0] a);
    return inv_r ? ~pattern(a) : pattern(a);
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] phase_pat(input logic [ADDR_WIDTH-1:0] a);
    return pattern(a);
  endfunction
`endif

  // Compare the read data against the address issued one cycle earlier.
  always_comb begin
    mis_s      = chk_valid_r && (data_out != phase_pat(chk_addr_r));
    err_next_s = error_count;
    ffa_next_s = first_fail_addr;
    if (mis_s) begin
      if (error_count != ERR_MAX) begin
        err_next_s = error_count + 1'b1;
      end else begin
        err_next_s = error_count;
      end
      if (error_count == {(ADDR_WIDTH+1){1'b0}}) begin
        ffa_next_s = chk_addr_r;
      end else begin
        ffa_next_s = first_fail_addr;
      end
    end else begin
      err_next_s = error_count;
      ffa_next_s = first_fail_addr;
    end
  end

  // Test sequencer with registered RAM and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      write_enable    <= 1'b0;
      address         <= {ADDR_WIDTH{1'b0}};
      data_in         <= {DATA_WIDTH{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= {(ADDR_WIDTH+1){1'b0}};
      first_fail_addr <= {ADDR_WIDTH{1'b0}};
      chk_addr_r      <= {ADDR_WIDTH{1'b0}};
      chk_valid_r     <= 1'b0;
`ifdef MEM_TEST_INVERT_PASS_EN
      inv_r           <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r         <= WRITE;
            write_enable    <= 1'b1;
            address         <= {ADDR_WIDTH{1'b0}};
            data_in         <= pattern({ADDR_WIDTH{1'b0}});
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            error_count     <= {(ADDR_WIDTH+1){1'b0}};
            first_fail_addr <= {ADDR_WIDTH{1'b0}};
            chk_valid_r     <= 1'b0;
`ifdef MEM_TEST_INVERT_PASS_EN
            inv_r           <= 1'b0;
`endif
          end else begin
            state_r <= state_r;
          end
        end
        WRITE: begin
          if (address == LAST_ADDR) begin
            state_r      <= READ;
            write_enable <= 1'b0;
            address      <= {ADDR_WIDTH{1'b0}};
            data_in      <= {DATA_WIDTH{1'b0}};
          end else begin
            address <= address + 1'b1;
            data_in <= phase_pat(address + 1'b1);
          end
        end
        READ: begin
          error_count     <= err_next_s;
          first_fail_addr <= ffa_next_s;
          chk_valid_r     <= 1'b1;
          chk_addr_r      <= address;
          if (address == LAST_ADDR) begin
            state_r <= DRAIN;
            address <= {ADDR_WIDTH{1'b0}};
          end else begin
            address <= address + 1'b1;
          end
        end
        DRAIN: begin
          error_count     <= err_next_s;
          first_fail_addr <= ffa_next_s;
          chk_valid_r     <= 1'b0;
`ifdef MEM_TEST_INVERT_PASS_EN
          if (!inv_r) begin
            inv_r        <= 1'b1;
            state_r      <= WRITE;
            write_enable <= 1'b1;
            address      <= {ADDR_WIDTH{1'b0}};
            data_in      <= ~pattern({ADDR_WIDTH{1'b0}});
          end else begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == {(ADDR_WIDTH+1){1'b0}});
          end
`else
          state_r <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_next_s == {(ADDR_WIDTH+1){1'b0}});
`endif
        end
        default: begin
          state_r      <= IDLE;
          write_enable <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
